elevator_ctrl: RTL and testbench
================================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 The block SHALL have parameter TRAVEL_CYCLES, default 8, giving the clock cycles per one-floor move (range 2..255).
REQ-002 The block SHALL have parameter DOOR_CYCLES, default 6, giving the clock cycles of door dwell (range 2..255).
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 CALL_G, CALL_L1, CALL_L2, CALL_L3  in  1 each  floor call buttons, level-sampled each edge, any width.
REQ-006 ESTOP  in  1  emergency stop, level.
REQ-007 state  out  3  position code feeding the downstream lamp decoder: 000 G, 001 L1, 010 L2, 011 L3, 100 emergency.
REQ-008 MOVING  out  1  cabin travelling between floors.
REQ-009 DOOR_OPEN  out  1  door dwell active.

Function
REQ-010 A 4-bit request register SHALL set bit n on any edge where call n is high; set has priority over clear on the same edge.
REQ-011 The internal FSM SHALL have states IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG.
REQ-012 The floor register SHALL be 2 bits (0..3), and state SHALL equal {1'b0, floor} in all FSM states except EMERG, where it is 100.
REQ-013 IDLE: if the request at the current floor is set -> DOOR next edge; else if any request is above -> MOVE_UP; else if any request is below -> MOVE_DOWN; else stay.
REQ-014 On entry to MOVE_UP/MOVE_DOWN, the travel timer SHALL load TRAVEL_CYCLES-1 and decrement each edge; on the edge where it is 0, floor SHALL increment or decrement by 1.
REQ-015 On arrival, if the request at the new floor is set -> DOOR; else continue in the same direction with the timer reloaded.
REQ-016 The direction policy SHALL be collective (SCAN): after DOOR, continue in the previous direction while requests remain ahead; otherwise reverse; otherwise IDLE.
REQ-017 On entry to DOOR, the request bit for the current floor SHALL clear and the dwell timer SHALL load DOOR_CYCLES-1; DOOR exits on the edge where the timer is 0.
REQ-018 A call for the current floor during DOOR SHALL reload the dwell timer and SHALL NOT leave the request bit set.
REQ-019 Floor SHALL saturate at 0 and 3; MOVE_UP at floor 3 and MOVE_DOWN at floor 0 are unreachable and SHALL fall back to IDLE.
REQ-020 MOVING SHALL be 1 exactly in MOVE_UP/MOVE_DOWN, and DOOR_OPEN SHALL be 1 exactly in DOOR.

Reset
REQ-021 rst SHALL force the following immediately, independent of clk: FSM to IDLE, floor 0, requests 0, both timers 0, state 000, MOVING 0, DOOR_OPEN 0.
REQ-022 Reset asserted mid-travel SHALL discard the partial move; floor returns to 0 with no recovery of position.

Configuration
REQ-023 With macro ELEVATOR_ESTOP_EN defined: ESTOP high SHALL force EMERG on the next edge from any state, clear all requests, freeze floor and ignore calls; on ESTOP low, EMERG SHALL exit to IDLE at the frozen floor.
REQ-024 Without ELEVATOR_ESTOP_EN: the ESTOP port SHALL remain but be ignored, EMERG SHALL not be reachable, and state 100 SHALL never be output.

Structure
REQ-025 The shared package elevator_pkg SHALL hold the 3-bit position codes (G, L1, L2, L3, EMERG), the FSM state enum, and the floor type.
REQ-026 One sub-module, elev_timer (load, value, decrement, zero flag), SHALL be instantiated twice, for travel and for dwell.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 Call response: from reset, pulse CALL_L2 at edge 0 -> MOVE_UP at edge 1, state 001 at edge 5, state 010 at edge 9, DOOR_OPEN high for edges 9..11, then IDLE with state 010.
REQ-028 Stop en route: at floor 0, pulse CALL_L3 at edge 0 and CALL_L1 at edge 2 -> stops at L1 (DOOR), then continues up to 011; the L1 bit is cleared at the stop.
REQ-029 Direction reversal: at L2 idle, pulse CALL_G and CALL_L3 on the same edge -> goes up to L3 first, then down to G, with no intermediate stops.
REQ-030 Door reopen: during DOOR at L1, hold CALL_L1 for 2 cycles -> dwell extends to end 3 cycles after the last call edge, and the request remains clear.
REQ-031 Emergency (ELEVATOR_ESTOP_EN): raise ESTOP mid-move from L1 -> state 100 next edge, MOVING 0, requests 0; drop ESTOP -> IDLE with state 001. Without the macro, the same stimulus has no effect.
REQ-032 Asynchronous reset: assert rst between clock edges during DOOR at L3 -> outputs 000/0/0 without a clock edge; after release, no spurious movement.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the four-floor elevator controller: position codes,
// FSM states, floor type and request-mask helpers.
package elevator_pkg;

  typedef logic [1:0] floor_t;
  typedef logic [2:0] pos_t;

  localparam pos_t POS_G     = 3'b000;
  localparam pos_t POS_L1    = 3'b001;
  localparam pos_t POS_L2    = 3'b010;
  localparam pos_t POS_L3    = 3'b011;
  localparam pos_t POS_EMERG = 3'b100;

  localparam floor_t TOP_FLOOR = 2'd3;
  localparam floor_t BOT_FLOOR = 2'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR,
    S_EMERG
  } fsm_t;

  function automatic logic [3:0] floor_bit(floor_t f);
    return 4'b0001 << f;
  endfunction

  function automatic logic [3:0] above_mask(floor_t f);
    return 4'b1110 << f;
  endfunction

  function automatic logic [3:0] below_mask(floor_t f);
    return ~(4'b1111 << f);
  endfunction

endpackage

// File: rtl/elevator_ctrl_timer.sv
// Loadable down-counter with zero flag, used for travel and door dwell.
// Holds at zero; load has priority over decrement.
module elev_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] init,
  input  logic       dec,
  output logic [7:0] value,
  output logic       zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'd0;
    end else if (load) begin
      value <= init;
    end else if (dec && value != 8'd0) begin
      value <= value - 8'd1;
    end
  end

  assign zero = (value == 8'd0);

endmodule

// File: rtl/elevator_ctrl.sv
// Four-floor collective (SCAN) elevator controller with travel/dwell timers.
// Optional emergency stop is enabled by defining ELEVATOR_ESTOP_EN.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CALL_G,
  input  logic       CALL_L1,
  input  logic       CALL_L2,
  input  logic       CALL_L3,
  input  logic       ESTOP,
  output logic [2:0] state,
  output logic       MOVING,
  output logic       DOOR_OPEN
);

  localparam logic [7:0] T_INIT = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] D_INIT = 8'(DOOR_CYCLES - 1);

  fsm_t       fsm, nxt;
  floor_t     floor, nfloor, up_floor, dn_floor;
  logic       dir_up, ndir;
  logic [3:0] req, req_nxt, call, clr, absorb;
  logic       above, below, go_up, go_dn, wipe;
  logic       t_load, t_dec, t_zero;
  logic       d_load, d_dec, d_zero;
  logic [7:0] t_init, d_init;
  logic [7:0] travel_unused, dwell_unused;

  assign call     = {CALL_L3, CALL_L2, CALL_L1, CALL_G};
  assign up_floor = floor_t'(floor + 2'd1);
  assign dn_floor = floor_t'(floor - 2'd1);
  assign above    = |(req & above_mask(floor));
  assign below    = |(req & below_mask(floor));
  // Keep sweeping the same way while work lies ahead, else turn round.
  assign go_up    = dir_up ? above : (above && !below);
  assign go_dn    = dir_up ? (below && !above) : below;

  elev_timer u_travel (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .init (t_init),
    .dec  (t_dec),
    .value(travel_unused),
    .zero (t_zero)
  );

  elev_timer u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (d_load),
    .init (d_init),
    .dec  (d_dec),
    .value(dwell_unused),
    .zero (d_zero)
  );

  always_comb begin
    nxt    = fsm;
    nfloor = floor;
    ndir   = dir_up;
    clr    = '0;
    absorb = '0;
    wipe   = 1'b0;
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_init = T_INIT;
    d_load = 1'b0;
    d_dec  = 1'b0;
    d_init = D_INIT;
    unique case (fsm)
      S_IDLE: begin
        if (req[floor]) begin
          nxt    = S_DOOR;
          clr    = floor_bit(floor);
          d_load = 1'b1;
        end else if (above) begin
          nxt    = S_MOVE_UP;
          ndir   = 1'b1;
          t_load = 1'b1;
        end else if (below) begin
          nxt    = S_MOVE_DOWN;
          ndir   = 1'b0;
          t_load = 1'b1;
        end
      end
      S_MOVE_UP: begin
        if (floor == TOP_FLOOR) begin
          nxt = S_IDLE;
        end else if (!t_zero) begin
          t_dec = 1'b1;
        end else begin
          nfloor = up_floor;
          if (req[up_floor]) begin
            nxt    = S_DOOR;
            clr    = floor_bit(up_floor);
            d_load = 1'b1;
          end else if (up_floor == TOP_FLOOR) begin
            nxt = S_IDLE;
          end else begin
            t_load = 1'b1;
          end
        end
      end
      S_MOVE_DOWN: begin
        if (floor == BOT_FLOOR) begin
          nxt = S_IDLE;
        end else if (!t_zero) begin
          t_dec = 1'b1;
        end else begin
          nfloor = dn_floor;
          if (req[dn_floor]) begin
            nxt    = S_DOOR;
            clr    = floor_bit(dn_floor);
            d_load = 1'b1;
          end else if (dn_floor == BOT_FLOOR) begin
            nxt = S_IDLE;
          end else begin
            t_load = 1'b1;
          end
        end
      end
      S_DOOR: begin
        // A call for the open floor only extends the dwell.
        clr    = floor_bit(floor);
        absorb = floor_bit(floor);
        if (call[floor]) begin
          d_load = 1'b1;
        end else if (!d_zero) begin
          d_dec = 1'b1;
        end else if (go_up) begin
          nxt    = S_MOVE_UP;
          ndir   = 1'b1;
          t_load = 1'b1;
        end else if (go_dn) begin
          nxt    = S_MOVE_DOWN;
          ndir   = 1'b0;
          t_load = 1'b1;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_EMERG: begin
        nxt    = S_IDLE;
        absorb = '1;
      end
      default: nxt = S_IDLE;
    endcase
`ifdef ELEVATOR_ESTOP_EN
    if (ESTOP) begin
      nxt    = S_EMERG;
      nfloor = floor;
      ndir   = dir_up;
      wipe   = 1'b1;
      t_load = 1'b1;
      t_dec  = 1'b0;
      t_init = 8'd0;
      d_load = 1'b1;
      d_dec  = 1'b0;
      d_init = 8'd0;
    end
`endif
    req_nxt = wipe ? '0 : ((req & ~clr) | (call & ~absorb));
  end

`ifndef ELEVATOR_ESTOP_EN
  logic estop_unused;
  assign estop_unused = ESTOP;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      floor     <= BOT_FLOOR;
      dir_up    <= 1'b1;
      req       <= '0;
      state     <= POS_G;
      MOVING    <= 1'b0;
      DOOR_OPEN <= 1'b0;
    end else begin
      fsm       <= nxt;
      floor     <= nfloor;
      dir_up    <= ndir;
      req       <= req_nxt;
      state     <= (nxt == S_EMERG) ? POS_EMERG : {1'b0, nfloor};
      MOVING    <= (nxt == S_MOVE_UP) || (nxt == S_MOVE_DOWN);
      DOOR_OPEN <= (nxt == S_DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a cycle-level behavioural model.
// Honours ELEVATOR_ESTOP_EN for the emergency scenario.
module tb_elevator_ctrl;

  localparam int T = 4;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic call_g = 0, call_l1 = 0, call_l2 = 0, call_l3 = 0, estop = 0;
  logic [2:0] state;
  logic moving, door_open;

  int vectors = 0;
  int miscompares = 0;
  bit running = 0;

  elevator_ctrl #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .CALL_G   (call_g),
    .CALL_L1  (call_l1),
    .CALL_L2  (call_l2),
    .CALL_L3  (call_l3),
    .ESTOP    (estop),
    .state    (state),
    .MOVING   (moving),
    .DOOR_OPEN(door_open)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 travelling, 2 door, 3 emergency.
  // m_left counts edges still to go in the current travel leg or dwell.
  int m_mode, m_pos, m_dir, m_left;
  bit [3:0] m_pend;

  function automatic bit pend_above(bit [3:0] p, int pos);
    for (int i = pos + 1; i < 4; i++) if (p[i]) return 1;
    return 0;
  endfunction

  function automatic bit pend_below(bit [3:0] p, int pos);
    for (int i = 0; i < pos; i++) if (p[i]) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_dir = 1; m_left = 0; m_pend = 0;
    end else begin
      bit [3:0] c, p, ignore;
      bit up, dn;
      c = {call_l3, call_l2, call_l1, call_g};
      p = m_pend;
      ignore = 0;
`ifdef ELEVATOR_ESTOP_EN
      if (estop) begin
        m_mode = 3; m_pend = 0; ignore = 4'hf;
      end else
`endif
      if (m_mode == 3) begin
        m_mode = 0; ignore = 4'hf;
      end else if (m_mode == 0) begin
        if (p[m_pos]) begin
          m_mode = 2; m_left = D; m_pend[m_pos] = 0;
        end else if (pend_above(p, m_pos)) begin
          m_mode = 1; m_dir = 1; m_left = T;
        end else if (pend_below(p, m_pos)) begin
          m_mode = 1; m_dir = -1; m_left = T;
        end
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_pos += m_dir;
          if (p[m_pos]) begin
            m_mode = 2; m_left = D; m_pend[m_pos] = 0;
          end else if (m_pos == 0 || m_pos == 3) m_mode = 0;
          else m_left = T;
        end
      end else begin
        ignore[m_pos] = 1;
        m_pend[m_pos] = 0;
        if (c[m_pos]) m_left = D;
        else begin
          m_left--;
          if (m_left == 0) begin
            up = pend_above(m_pend, m_pos);
            dn = pend_below(m_pend, m_pos);
            if (up && (m_dir > 0 || !dn)) begin
              m_mode = 1; m_dir = 1; m_left = T;
            end else if (dn) begin
              m_mode = 1; m_dir = -1; m_left = T;
            end else m_mode = 0;
          end
        end
      end
      m_pend = m_pend | (c & ~ignore);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (running && !rst) begin
      chk("model_state", int'(state), (m_mode == 3) ? 4 : m_pos);
      chk("model_moving", int'(moving), int'(m_mode == 1));
      chk("model_door", int'(door_open), int'(m_mode == 2));
    end
  end

  task automatic tick(input logic [3:0] c, input logic e);
    {call_l3, call_l2, call_l1, call_g} = c;
    estop = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_settle(input int budget);
    int n = 0;
    while ((moving || door_open || m_pend != 0) && n < budget) begin
      tick(4'b0000, 1'b0);
      n++;
    end
    chk("settle_timeout", int'(n >= budget), 0);
  endtask

  task automatic wait_door_l3(input int budget);
    int n = 0;
    while (!(door_open && state == 3'b011) && n < budget) begin
      tick(4'b0000, 1'b0);
      n++;
    end
    chk("door_l3_timeout", int'(n >= budget), 0);
  endtask

  initial begin
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_door", int'(door_open), 0);
    @(negedge clk);
    rst = 1'b0;
    running = 1;

    // Call response: G -> L2
    tick(4'b0100, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick(4'b0000, 1'b0);
      if (k == 1) chk("s1_move_e1", int'(moving), 1);
      if (k == 4) chk("s1_state_e4", int'(state), 0);
      if (k == 5) chk("s1_state_e5", int'(state), 1);
      if (k == 9) chk("s1_state_e9", int'(state), 2);
      if (k == 9) chk("s1_door_e9", int'(door_open), 1);
      if (k == 11) chk("s1_door_e11", int'(door_open), 1);
      if (k == 12) chk("s1_door_e12", int'(door_open), 0);
      if (k == 12) chk("s1_idle_e12", int'(moving), 0);
    end

    // Stop en route at L1 on the way to L3
    do_reset();
    tick(4'b1000, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      tick((k == 2) ? 4'b0010 : 4'b0000, 1'b0);
      if (k == 5) chk("s2_l1_state", int'(state), 1);
      if (k == 5) chk("s2_l1_door", int'(door_open), 1);
      if (k == 6) chk("s2_req", int'(dut.req), 8);
      if (k == 8) chk("s2_resume", int'(moving), 1);
      if (k == 16) chk("s2_l3_state", int'(state), 3);
      if (k == 16) chk("s2_l3_door", int'(door_open), 1);
      if (k == 19) chk("s2_done", int'(door_open | moving), 0);
    end

    // Reversal: idle at L2, calls for G and L3 together
    tick(4'b0100, 1'b0);
    wait_settle(40);
    chk("s3_start", int'(state), 2);
    tick(4'b1001, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick(4'b0000, 1'b0);
      if (k == 5) chk("s3_l3_door", int'(door_open), 1);
      if (k == 8) chk("s3_turn", int'(moving), 1);
      if (k == 12) chk("s3_pass_l2", int'({state, moving, door_open}), 10);
      if (k == 16) chk("s3_pass_l1", int'({state, moving, door_open}), 6);
      if (k == 20) chk("s3_g_door", int'({state, moving, door_open}), 1);
    end
    wait_settle(20);

    // Door reopen at L1
    tick(4'b0010, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick((k == 6 || k == 7) ? 4'b0010 : 4'b0000, 1'b0);
      if (k == 5) chk("s4_door_open", int'(door_open), 1);
      if (k == 9) chk("s4_door_held", int'(door_open), 1);
      if (k == 9) chk("s4_req_clear", int'(dut.req), 0);
      if (k == 10) chk("s4_door_shut", int'(door_open), 0);
      if (k == 10) chk("s4_state", int'(state), 1);
    end

    // Emergency stop mid-move from L1
    tick(4'b1000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b0);
    tick(4'b0000, 1'b1);
`ifdef ELEVATOR_ESTOP_EN
    chk("s5_emerg_state", int'(state), 4);
    chk("s5_emerg_moving", int'(moving), 0);
    chk("s5_emerg_req", int'(dut.req), 0);
    tick(4'b0100, 1'b1);
    chk("s5_calls_ignored", int'(dut.req), 0);
    tick(4'b0000, 1'b0);
    chk("s5_exit_state", int'(state), 1);
    tick(4'b0000, 1'b0);
    chk("s5_exit_moving", int'(moving), 0);
`else
    chk("s5_noestop_state", int'(state), 1);
    chk("s5_noestop_moving", int'(moving), 1);
    tick(4'b0000, 1'b0);
    wait_settle(40);
    chk("s5_noestop_l3", int'(state), 3);
`endif

    // Asynchronous reset during door at L3
    tick(4'b1000, 1'b0);
    wait_door_l3(40);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_state", int'(state), 0);
    chk("s6_async_door", int'(door_open), 0);
    chk("s6_async_moving", int'(moving), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick(4'b0000, 1'b0);
    chk("s6_quiet", int'({state, moving, door_open}), 0);

    running = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

endmodule
